// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the 10-step PWM generator and its duty ramp controller.
package pwm_ctrl_pkg;

  localparam int unsigned PWM_DUTY_W   = 4;
  localparam int unsigned PWM_DUTY_MAX = 10;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/pwm_ramp_div.sv
// Counts PWM periods while a ramp is active; tick marks the last period of each ramp step.
module pwm_ramp_div #(
  parameter int unsigned RAMP_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic period_end,
  output logic tick
);

  localparam int unsigned      CNT_W = $clog2(RAMP_DIV) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (period_end) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Combinational so the duty step lands on the same edge as the period boundary.
  assign tick = period_end & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Owns the PWM duty setting: tracks a target from inc/dec/load requests and slews the
// applied duty toward it one step per RAMP_DIV periods, only on period boundaries.
module pwm_duty_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned DUTY_W    = PWM_DUTY_W,
  parameter int unsigned DUTY_MAX  = PWM_DUTY_MAX,
  parameter int unsigned DUTY_INIT = 5,
  parameter int unsigned RAMP_DIV  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_end,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              load,
  input  logic [DUTY_W-1:0] load_duty,
  output logic [DUTY_W-1:0] duty_out,
  output logic [DUTY_W-1:0] target_out,
  output logic              busy,
  output logic              clamp
);

  localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_D = DUTY_W'(DUTY_INIT);

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              clamp_q, clamp_d;
  logic              busy_q;
  logic              step_tick;

  pwm_ramp_div #(
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp_div (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q == HOLD),
    .period_end (period_end),
    .tick       (step_tick)
  );

  // Target update: load wins; simultaneous inc and dec cancel.
  always_comb begin
    target_d = target_q;
    clamp_d  = 1'b0;
    if (load) begin
      if (load_duty > MAX_D) begin
        target_d = MAX_D;
        clamp_d  = 1'b1;
      end else begin
        target_d = load_duty;
      end
    end else if (inc_pulse && !dec_pulse) begin
      if (target_q < MAX_D) target_d = target_q + DUTY_W'(1);
    end else if (dec_pulse && !inc_pulse) begin
      if (target_q != '0) target_d = target_q - DUTY_W'(1);
    end
  end

  // Ramp direction from the registered target and duty.
  always_comb begin
    state_d = HOLD;
    if (target_q > duty_q) begin
      state_d = UP;
    end else if (target_q < duty_q) begin
      state_d = DOWN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Guards against overshoot while the state lags a target change by one cycle.
  always_comb begin
    duty_d = duty_q;
    if (step_tick) begin
      if (state_q == UP && duty_q < target_q) begin
        duty_d = duty_q + DUTY_W'(1);
      end else if (state_q == DOWN && duty_q > target_q) begin
        duty_d = duty_q - DUTY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q   <= '0;
      target_q <= INIT_D;
      clamp_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      duty_q   <= duty_d;
      target_q <= target_d;
      clamp_q  <= clamp_d;
      busy_q   <= (state_d != HOLD);
    end
  end

  assign duty_out   = duty_q;
  assign target_out = target_q;
  assign busy       = busy_q;
  assign clamp      = clamp_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl: soft start, saturation, clamp, reversal and async reset.
module tb_pwm_duty_ramp_ctrl;
  import pwm_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       period_end;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       load;
  logic [3:0] load_duty;
  logic [3:0] duty_out;
  logic [3:0] target_out;
  logic       busy;
  logic       clamp;

  int checks   = 0;
  int failures = 0;

  logic       pe_last   = 1'b0;
  logic [3:0] duty_prev = 4'd0;
  logic [3:0] max_duty  = 4'd0;

  pwm_duty_ramp_ctrl #(
    .DUTY_W    (4),
    .DUTY_MAX  (10),
    .DUTY_INIT (5),
    .RAMP_DIV  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .period_end (period_end),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .load       (load),
    .load_duty  (load_duty),
    .duty_out   (duty_out),
    .target_out (target_out),
    .busy       (busy),
    .clamp      (clamp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
    end
  endtask

  // One clock: inputs were set before the edge, pulses drop 1 time unit after it.
  task automatic clk1();
    @(posedge clk);
    #1;
    period_end = 1'b0;
    inc_pulse  = 1'b0;
    dec_pulse  = 1'b0;
    load       = 1'b0;
  endtask

  task automatic run_periods(input int n);
    for (int p = 0; p < n; p++) begin
      repeat (9) clk1();
      period_end = 1'b1;
      clk1();
    end
  endtask

  always @(posedge clk) pe_last <= period_end;

  // Duty may only move in the clock right after a period_end pulse.
  always @(negedge clk) begin
    if (!rst && duty_out != duty_prev) check("step_after_pe", 32'(pe_last), 32'd1);
    if (duty_out > max_duty) max_duty = duty_out;
    duty_prev = duty_out;
  end

  initial begin
    rst = 1'b1; period_end = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
    load = 1'b0; load_duty = 4'd0;
    clk1(); clk1();
    check("rst_duty", 32'(duty_out), 32'd0);
    check("rst_target", 32'(target_out), 32'd5);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clamp", 32'(clamp), 32'd0);
    rst = 1'b0;

    // Soft start 0 -> 5, one step every second period.
    clk1();
    check("soft_busy0", 32'(busy), 32'd1);
    check("soft_state_up", 32'(dut.state_q), 32'(UP));
    for (int k = 1; k <= 5; k++) begin
      run_periods(1);
      check("soft_mid", 32'(duty_out), 32'(k - 1));
      run_periods(1);
      check("soft_step", 32'(duty_out), 32'(k));
    end
    check("soft_busy_at5", 32'(busy), 32'd1);
    clk1();
    check("soft_busy_drop", 32'(busy), 32'd0);

    // Five increments reach full scale, a sixth saturates.
    for (int i = 0; i < 5; i++) begin
      inc_pulse = 1'b1;
      clk1();
    end
    check("inc_target10", 32'(target_out), 32'd10);
    inc_pulse = 1'b1;
    clk1();
    check("inc_sat", 32'(target_out), 32'd10);
    run_periods(9);
    check("inc_duty9", 32'(duty_out), 32'd9);
    run_periods(1);
    check("inc_duty10", 32'(duty_out), 32'd10);
    run_periods(2);
    check("inc_duty_hold", 32'(duty_out), 32'd10);
    check("inc_busy_off", 32'(busy), 32'd0);

    // Clamped load beats a concurrent inc; clamp is a single-cycle pulse.
    load = 1'b1; load_duty = 4'd15; inc_pulse = 1'b1;
    clk1();
    check("clamp_target", 32'(target_out), 32'd10);
    check("clamp_pulse", 32'(clamp), 32'd1);
    clk1();
    check("clamp_drop", 32'(clamp), 32'd0);
    load = 1'b1; load_duty = 4'd3;
    clk1();
    check("load3_target", 32'(target_out), 32'd3);
    clk1();
    check("down_state", 32'(dut.state_q), 32'(DOWN));
    check("down_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      run_periods(2);
      check("down_step", 32'(duty_out), 32'(10 - k));
    end
    clk1();
    check("down_busy_off", 32'(busy), 32'd0);

    // Back to 5, then inc+dec together must not move anything.
    load = 1'b1; load_duty = 4'd5;
    clk1();
    run_periods(4);
    clk1();
    check("back5_duty", 32'(duty_out), 32'd5);
    inc_pulse = 1'b1; dec_pulse = 1'b1;
    clk1();
    check("incdec_target", 32'(target_out), 32'd5);
    run_periods(2);
    check("incdec_duty", 32'(duty_out), 32'd5);
    check("incdec_busy", 32'(busy), 32'd0);

    // dec at zero target holds at zero.
    load = 1'b1; load_duty = 4'd0;
    clk1();
    dec_pulse = 1'b1;
    clk1();
    check("dec_at0", 32'(target_out), 32'd0);
    load = 1'b1; load_duty = 4'd2;
    clk1();
    check("load2_target", 32'(target_out), 32'd2);
    run_periods(6);
    check("load2_duty", 32'(duty_out), 32'd2);
    clk1();
    check("load2_busy_off", 32'(busy), 32'd0);

    // Reversal: ramp toward 8, reverse to 1 at duty 4 with the divider half-way.
    load = 1'b1; load_duty = 4'd8;
    clk1();
    run_periods(4);
    check("rev_up4", 32'(duty_out), 32'd4);
    run_periods(1);
    check("rev_half", 32'(duty_out), 32'd4);
    max_duty = 4'd0;
    load = 1'b1; load_duty = 4'd1;
    clk1();
    run_periods(1);
    check("rev_no_divclr", 32'(duty_out), 32'd3);
    run_periods(2);
    check("rev_duty2", 32'(duty_out), 32'd2);
    run_periods(2);
    check("rev_duty1", 32'(duty_out), 32'd1);
    clk1();
    check("rev_busy_off", 32'(busy), 32'd0);
    check("rev_no_overshoot", 32'(max_duty), 32'd4);

    // Async reset mid-ramp at duty 6, between clock edges.
    load = 1'b1; load_duty = 4'd8;
    clk1();
    run_periods(10);
    check("pre_rst_duty6", 32'(duty_out), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    check("arst_duty", 32'(duty_out), 32'd0);
    check("arst_target", 32'(target_out), 32'd5);
    check("arst_busy", 32'(busy), 32'd0);
    clk1(); clk1();
    rst = 1'b0;
    clk1();
    check("resoft_busy", 32'(busy), 32'd1);
    run_periods(2);
    check("resoft_duty1", 32'(duty_out), 32'd1);
    run_periods(8);
    check("resoft_duty5", 32'(duty_out), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
Name: pwm_duty_ramp_ctrl

Overview:
- Configuration controller for the 10-step PWM generator. It owns the duty-cycle setting and drives the generator's duty input.
- Accepts debounced inc/dec pulses and a direct load from a host register, and keeps a target duty.
- Slews the applied duty toward the target by one step every RAMP_DIV PWM periods. Steps are applied only on a period boundary, so the output is glitch-free. Power-up is a soft start.

Parameters:
- DUTY_W, 4, width of duty values.
- DUTY_MAX, 10, full-scale duty (100%); also the generator period in clocks.
- DUTY_INIT, 5, target loaded at reset (50%).
- RAMP_DIV, 2, PWM periods per ramp step; legal range 1..16.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- period_end  in  1  one-cycle pulse from the PWM counter on its last count (counter == DUTY_MAX-1).
- inc_pulse  in  1  debounced one-cycle request: target +1.
- dec_pulse  in  1  debounced one-cycle request: target -1.
- load  in  1  one-cycle strobe: target <= load_duty.
- load_duty  in  DUTY_W  requested target value.
- duty_out  out  DUTY_W  applied duty, wired to the PWM comparator.
- target_out  out  DUTY_W  current target.
- busy  out  1  ramp in progress (state != HOLD).
- clamp  out  1  one-cycle pulse: a load value was clamped to DUTY_MAX.

Behaviour:
- Reset (async, active-high):
  - duty_out=0, target=DUTY_INIT, state=HOLD, div_cnt=0, clamp=0, busy=0.
  - After reset release, the block ramps 0 -> DUTY_INIT (soft start).
- Target update, registered, one per clock. Priority is load > inc/dec:
  - load: target <= min(load_duty, DUTY_MAX). clamp=1 next cycle if load_duty > DUTY_MAX.
  - inc_pulse only: target <= min(target+1, DUTY_MAX). No action at DUTY_MAX.
  - dec_pulse only: target <= target-1 if target > 0. No action at 0.
  - inc and dec in the same cycle: no change.
  - load together with inc/dec: inc/dec are ignored.
- State register (states HOLD, UP, DOWN), evaluated every clock from the registered target and duty_out:
  - next = UP if target > duty_out.
  - next = DOWN if target < duty_out.
  - otherwise next = HOLD.
- Ramp divider div_cnt (width clog2(RAMP_DIV)+1):
  - Held at 0 while state=HOLD.
  - In UP/DOWN it increments on period_end and wraps to 0 after RAMP_DIV-1.
  - A direction reversal (UP<->DOWN) does not clear div_cnt.
- Step event = period_end & (state != HOLD) & (div_cnt == RAMP_DIV-1):
  - UP: duty_out <= duty_out+1, only if duty_out < target (current registered values).
  - DOWN: duty_out <= duty_out-1, only if duty_out > target.
  - These guards prevent overshoot when the target moves during the one-cycle state lag.
- duty_out changes only in the clock after a period_end pulse. It never changes mid-period.
- busy = (state != HOLD), registered. It deasserts in the cycle after duty_out reaches target.
- Latency:
  - First step after leaving HOLD occurs on the RAMP_DIV-th period_end.
  - Full ramp of N steps takes N*RAMP_DIV periods.
- Invariants:
  - duty_out never exceeds DUTY_MAX and never underflows.
  - target is always in 0..DUTY_MAX.
- period_end asserted on consecutive cycles: each pulse counts. The upstream contract is one pulse per DUTY_MAX clocks.
- Reset asserted mid-ramp: immediate return to reset values. The soft start restarts on release.

Decomposition:
- Package pwm_ctrl_pkg:
  - state typedef {HOLD, UP, DOWN}.
  - Constants PWM_DUTY_W=4 and PWM_DUTY_MAX=10, shared with the PWM generator.
- One sub-module, pwm_ramp_div:
  - Period-divider counter.
  - Inputs: clk, rst, clr, period_end.
  - Output: tick on the final count.
- Target logic, FSM and duty register stay in the top.

Test Plan:
- Soft start: RAMP_DIV=2, period_end every 10 clks, reset released -> duty_out steps 0,1,..,5 after period_end #2,#4,..,#10. busy high throughout, low one clk after duty_out=5. duty_out never changes except the clk after period_end.
- Inc/saturate: from HOLD at 5, five inc pulses -> target 10. A sixth pulse leaves target 10. duty_out reaches 10 after 10 period_ends and stays.
- Load clamp and priority: load=1 with load_duty=15 and inc_pulse=1 -> target=10, clamp=1 for exactly one clk. Then load_duty=3 -> ramps down to 3, DOWN state observed.
- Simultaneous inc+dec at target 5 -> target stays 5. dec at target 0 -> stays 0. No step, busy stays 0.
- Reversal mid-ramp: ramping 2->8 at duty 4, load 1 -> duty_out goes 4,3,2,1 with no overshoot above 4. div_cnt not cleared across the reversal.
- Reset mid-ramp: assert rst asynchronously at duty 6 between clk edges -> duty_out=0 and target=5 immediately, without waiting for a clk edge. After release, the soft start repeats.
